// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment 74HC595 scan back-end.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} for a common-anode display.
package seg_pkg;

   localparam int FRAME_W    = 16;
   localparam int NUM_DIGITS = 6;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ERR   = 8'h86;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_LATCH
   } state_t;

   // Non-BCD nibbles (A-F) render as 'E' so a converter fault is visible.
   function automatic logic [7:0] digit_code(input logic [3:0] nib);
      logic [7:0] code;
      case (nib)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_ERR;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg_scan_595_decode.sv
// Combinational segment encoder: BCD nibble plus blank/minus/dp flags to an
// active-low segment byte. Minus wins over blank, and dp survives blanking.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       minus,
   input  logic       dp,
   output logic [7:0] seg
);

   logic [7:0] base;

   always_comb begin
      base = digit_code(nibble);
      if (blank) base = SEG_BLANK;
      if (minus) base = SEG_MINUS;
      seg = base;
      if (dp) seg[7] = 1'b0;
   end

endmodule

// File: rtl/seg_scan_595.sv
// Six-digit multiplexed display driver: one 16-bit {seg,sel} frame is shifted
// MSB first into two chained 74HC595s and latched on every refresh tick.
module seg_scan_595
   import seg_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int SCLK_DIV = 2
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [19:0] dec,
   input  logic        sign,
   input  logic [5:0]  dp_en,
   output logic        ds_data,
   output logic        ds_shcp,
   output logic        ds_stcp
);

   // A full frame takes 1 + 33*SCLK_DIV cycles and must fit inside one tick period.
   localparam int TICK_MAX = CLK_FREQ / SCAN_HZ;
   localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_MAX - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCLK_DIV - 1);
   localparam logic [2:0]        DIGIT_LAST = 3'(NUM_DIGITS - 1);

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                high_q, high_d;
   logic [3:0]          bit_q, bit_d;
   logic [2:0]          digit_q, digit_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [19:0]         dec_q, dec_d;
   logic                sign_q, sign_d;
   logic [5:0]          dp_q, dp_d;
   logic                data_q, data_d;
   logic                shcp_q, shcp_d;
   logic                stcp_q, stcp_d;

   logic                tick;
   logic [19:0]         cur_dec;
   logic                cur_sign;
   logic [5:0]          cur_dp;
   logic [3:0]          nibble;
   logic                blank;
   logic                minus;
   logic                dp_bit;
   logic [7:0]          seg_code;
   logic [7:0]          sel_code;
   logic [FRAME_W-1:0]  frame_new;

   assign ds_data = data_q;
   assign ds_shcp = shcp_q;
   assign ds_stcp = stcp_q;

   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   // The digit-0 LOAD must show the value it captures, so bypass the snapshot there.
   always_comb begin
      cur_dec  = (digit_q == 3'd0) ? dec   : dec_q;
      cur_sign = (digit_q == 3'd0) ? sign  : sign_q;
      cur_dp   = (digit_q == 3'd0) ? dp_en : dp_q;
      nibble   = 4'h0;
      blank    = 1'b0;
      minus    = 1'b0;
      case (digit_q)
         3'd0: nibble = cur_dec[3:0];
         3'd1: begin
            nibble = cur_dec[7:4];
            blank  = (cur_dec[19:4] == 16'h0);
         end
         3'd2: begin
            nibble = cur_dec[11:8];
            blank  = (cur_dec[19:8] == 12'h0);
         end
         3'd3: begin
            nibble = cur_dec[15:12];
            blank  = (cur_dec[19:12] == 8'h0);
         end
         3'd4: begin
            nibble = cur_dec[19:16];
            blank  = (cur_dec[19:16] == 4'h0);
         end
         3'd5: begin
            minus = cur_sign;
            blank = ~cur_sign;
         end
         default: blank = 1'b1;
      endcase
      dp_bit    = (digit_q <= DIGIT_LAST) ? cur_dp[digit_q] : 1'b0;
      sel_code  = ~(8'd1 << digit_q);
      frame_new = {seg_code, sel_code};
   end

   seg_decode u_decode (
      .nibble (nibble),
      .blank  (blank),
      .minus  (minus),
      .dp     (dp_bit),
      .seg    (seg_code)
   );

   // Output flops are computed for the state being entered, so each pin changes
   // on the same edge as the FSM and carries no decode glitches.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      high_d  = high_q;
      bit_d   = bit_q;
      digit_d = digit_q;
      frame_d = frame_q;
      dec_d   = dec_q;
      sign_d  = sign_q;
      dp_d    = dp_q;
      data_d  = 1'b0;
      shcp_d  = 1'b0;
      stcp_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tick) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (digit_q == 3'd0) begin
               dec_d  = dec;
               sign_d = sign;
               dp_d   = dp_en;
            end
            frame_d = frame_new;
            bit_d   = 4'd15;
            div_d   = '0;
            high_d  = 1'b0;
            data_d  = frame_new[FRAME_W-1];
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            data_d = frame_q[bit_q];
            shcp_d = high_q;
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!high_q) begin
                  high_d = 1'b1;
                  shcp_d = 1'b1;
               end else if (bit_q == 4'd0) begin
                  state_d = ST_LATCH;
                  data_d  = 1'b0;
                  shcp_d  = 1'b0;
                  stcp_d  = 1'b1;
               end else begin
                  high_d = 1'b0;
                  bit_d  = bit_q - 4'd1;
                  data_d = frame_q[bit_q - 4'd1];
                  shcp_d = 1'b0;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_LATCH: begin
            stcp_d = 1'b1;
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               stcp_d  = 1'b0;
               state_d = ST_IDLE;
               digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         div_q      <= '0;
         high_q     <= 1'b0;
         bit_q      <= 4'd0;
         digit_q    <= 3'd0;
         frame_q    <= '0;
         dec_q      <= 20'h0;
         sign_q     <= 1'b0;
         dp_q       <= 6'h0;
         data_q     <= 1'b0;
         shcp_q     <= 1'b0;
         stcp_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         div_q      <= div_d;
         high_q     <= high_d;
         bit_q      <= bit_d;
         digit_q    <= digit_d;
         frame_q    <= frame_d;
         dec_q      <= dec_d;
         sign_q     <= sign_d;
         dp_q       <= dp_d;
         data_q     <= data_d;
         shcp_q     <= shcp_d;
         stcp_q     <= stcp_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_595.sv
// Scoreboard bench for seg_scan_595: stimulus pushes expected frames from a
// digit-level display model, a monitor decodes the 595 pins and compares.
module tb_seg_scan_595;

   localparam int CLK_FREQ = 1000;
   localparam int SCAN_HZ  = 10;
   localparam int SCLK_DIV = 2;
   localparam int TICK_MAX = CLK_FREQ / SCAN_HZ;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] dec = 20'h0;
   logic        sign = 1'b0;
   logic [5:0]  dp_en = 6'h0;
   logic        ds_data;
   logic        ds_shcp;
   logic        ds_stcp;

   int          tests = 0;
   int          failures = 0;
   logic [15:0] exp_q [$];
   int          latches_seen = 0;
   int          shcp_rises = 0;
   int          cyc;

   seg_scan_595 #(
      .CLK_FREQ (CLK_FREQ),
      .SCAN_HZ  (SCAN_HZ),
      .SCLK_DIV (SCLK_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dec     (dec),
      .sign    (sign),
      .dp_en   (dp_en),
      .ds_data (ds_data),
      .ds_shcp (ds_shcp),
      .ds_stcp (ds_stcp)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; ticks land on multiples of TICK_MAX.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Display model: what digit k should show for a given value/sign/dp word.
   function automatic logic [15:0] model_frame(input logic [19:0] v, input logic s,
                                               input logic [5:0] dp, input int k);
      logic [7:0]  tab [0:9];
      logic [7:0]  seg;
      logic [19:0] upper;
      int          nib;
      tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      if (k == 5) begin
         seg = s ? 8'hBF : 8'hFF;
      end else begin
         upper = v >> (4 * k);
         nib   = int'(upper & 20'hF);
         if (k > 0 && upper == 20'h0) seg = 8'hFF;
         else if (nib > 9)            seg = 8'h86;
         else                         seg = tab[nib];
      end
      if (dp[k]) seg = seg & 8'h7F;
      return {seg, 8'hFF ^ (8'h01 << k)};
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [19:0] v, input logic s, input logic [5:0] dp);
      dec   = v;
      sign  = s;
      dp_en = dp;
      for (int k = 0; k < 6; k++) exp_q.push_back(model_frame(v, s, dp, k));
   endtask

   task automatic wait_latches(input int n);
      int target;
      int spent;
      target = latches_seen + n;
      spent  = 0;
      while (latches_seen < target && spent < n * TICK_MAX + 200) begin
         @(negedge clk);
         spent++;
      end
      if (latches_seen < target) checkOutput("latch_timeout", latches_seen, target);
   endtask

   // Finish the current round; after k of its latches, set up the next round.
   task automatic run_round(input int k, input logic [19:0] v, input logic s,
                            input logic [5:0] dp);
      wait_latches(k);
      applyStimulus(v, s, dp);
      wait_latches(6 - k);
   endtask

   // Monitor: shift in ds_data on shcp rises, compare on stcp rise, time on stcp fall.
   initial begin
      logic [15:0] acc;
      int          nbits;
      int          last_chg;
      logic        prev_data, prev_shcp, prev_stcp;
      logic [15:0] expv;
      acc = 16'h0; nbits = 0; last_chg = 0;
      prev_data = 1'b0; prev_shcp = 1'b0; prev_stcp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc = 16'h0; nbits = 0; last_chg = 0;
            prev_data = 1'b0; prev_shcp = 1'b0; prev_stcp = 1'b0;
         end else begin
            if (ds_data !== prev_data) last_chg = cyc;
            if (ds_shcp && !prev_shcp) begin
               if (nbits == 0) checkOutput("frame_start_phase", cyc % TICK_MAX, 1 + SCLK_DIV);
               checkOutput("data_setup_ok", int'((cyc - last_chg) >= SCLK_DIV), 1);
               acc = {acc[14:0], ds_data};
               nbits++;
               shcp_rises++;
            end
            if (ds_stcp && !prev_stcp) begin
               checkOutput("frame_bits", nbits, 16);
               if (exp_q.size() == 0) begin
                  tests++;
                  failures++;
                  $display("[TB] FAIL frame_unexpected: got %h, expected no frame", acc);
               end else begin
                  expv = exp_q.pop_front();
                  checkOutput("frame", int'(acc), int'(expv));
               end
               nbits = 0;
            end
            if (!ds_stcp && prev_stcp) begin
               checkOutput("stcp_fall_phase", cyc % TICK_MAX, 1 + 33 * SCLK_DIV);
               latches_seen++;
            end
            prev_data = ds_data;
            prev_shcp = ds_shcp;
            prev_stcp = ds_stcp;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [19:0] v;
      logic        s;
      logic [5:0]  dp;
      int          nz, nib, k, saved, target, spent;

      rst_n = 1'b0;
      applyStimulus(20'h01234, 1'b0, 6'b000000);
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", int'({ds_data, ds_shcp, ds_stcp}), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (50) @(negedge clk);
      checkOutput("idle_before_first_tick", int'({ds_data, ds_shcp, ds_stcp}), 0);

      run_round(6, 20'h01234, 1'b0, 6'b000000);
      run_round(6, 20'h00005, 1'b1, 6'b000000);
      run_round(6, 20'h00000, 1'b0, 6'b000100);
      run_round(6, 20'h0000A, 1'b0, 6'b000000);
      run_round(6, 20'h12345, 1'b0, 6'b000100);
      run_round(6, 20'h01234, 1'b0, 6'b000000);
      // Mid-round change after the digit-2 latch only affects the following round.
      run_round(3, 20'h05678, 1'b0, 6'b000000);

      for (int r = 0; r < 10; r++) begin
         nz = $urandom_range(0, 5);
         v  = 20'h0;
         for (int d = 0; d < 5; d++) begin
            nib = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            if (d >= 5 - nz) nib = 0;
            v[4*d +: 4] = 4'(nib);
         end
         s  = 1'($urandom_range(0, 1));
         dp = 6'($urandom_range(0, 63));
         k  = $urandom_range(1, 6);
         run_round(k, v, s, dp);
      end

      // Reset in the middle of shifting digit 3.
      wait_latches(3);
      target = shcp_rises + 4;
      spent  = 0;
      while (shcp_rises < target && spent < 300) begin
         @(negedge clk);
         spent++;
      end
      if (shcp_rises < target) checkOutput("shift_timeout", shcp_rises, target);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("reset_async_outputs", int'({ds_data, ds_shcp, ds_stcp}), 0);
      saved = latches_seen;
      repeat (20) @(negedge clk);
      checkOutput("reset_hold_outputs", int'({ds_data, ds_shcp, ds_stcp}), 0);
      checkOutput("no_latch_in_reset", latches_seen, saved);
      exp_q.delete();
      applyStimulus(20'h00789, 1'b1, 6'b100001);
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_latches(6);
      checkOutput("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
